// File: rtl/seg7_if.sv
// Display-word and scan-output bundle for the seven-segment scanner.
interface seg7_if;
  logic [31:0] data_i;
  logic        load_i;
  logic [7:0]  blank_i;
  logic [7:0]  dp_i;
  logic        lz_en_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  modport master (output data_i, load_i, blank_i, dp_i, lz_en_i,
                  input  an_o, seg_o, dp_o, frame_o);
  modport slave  (input  data_i, load_i, blank_i, dp_i, lz_en_i,
                  output an_o, seg_o, dp_o, frame_o);
endinterface

// File: rtl/seg7_scanner.sv
// 8-digit common-anode hex scanner; new words are double-buffered and
// committed only at frame wrap so a digit never shows a torn value.
module seg7_scanner #(
  parameter int SCAN_DIV = 100000
) (
  input  logic   clk_i,
  input  logic   rst_i,
  seg7_if.slave  bus
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;
  logic [2:0]    dig;
  logic [31:0]   pend, disp;
  logic          pend_v;
  logic          tick, wrap;
  logic [7:0]    lz_mask;
  logic [3:0]    nib;
  logic          dark;

  assign tick = (div == DW'(SCAN_DIV - 1));
  assign wrap = tick && (dig == 3'd7);

  // Digit k goes dark when it and every more-significant nibble are zero.
  assign lz_mask[0] = 1'b0;
  for (genvar k = 1; k < 8; k++) begin : g_lz
    assign lz_mask[k] = bus.lz_en_i && (disp[31:4*k] == '0);
  end

  assign nib  = disp[{dig, 2'b00} +: 4];
  assign dark = bus.blank_i[dig] | lz_mask[dig];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div         <= '0;
      dig         <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      disp        <= '0;
      bus.an_o    <= 8'hFF;
      bus.seg_o   <= 7'h7F;
      bus.dp_o    <= 1'b1;
      bus.frame_o <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) dig <= dig + 3'd1;

      // A load landing exactly on wrap bypasses the pending stage.
      if (wrap && bus.load_i) begin
        pend   <= bus.data_i;
        disp   <= bus.data_i;
        pend_v <= 1'b0;
      end else begin
        if (bus.load_i) begin
          pend   <= bus.data_i;
          pend_v <= 1'b1;
        end
        if (wrap && pend_v) begin
          disp   <= pend;
          pend_v <= 1'b0;
        end
      end

      bus.frame_o <= wrap;
      if (dark) begin
        bus.an_o  <= 8'hFF;
        bus.seg_o <= 7'h7F;
        bus.dp_o  <= 1'b1;
      end else begin
        bus.an_o  <= ~(8'b1 << dig);
        bus.seg_o <= hex7(nib);
        bus.dp_o  <= ~bus.dp_i[dig];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboarded bench: a frame-level model predicts each cycle's outputs.
module tb_seg7_scanner;
  localparam int SD = 4;
  localparam int FRAME = 8 * SD;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  seg7_if bus ();
  seg7_scanner #(.SCAN_DIV(SD)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t        expq[$];
  logic [31:0] frame_loads[$];
  logic [31:0] disp_m;
  int          t;
  int          checks = 0;
  int          failures = 0;

  // Reference: position in the frame comes from elapsed cycles since reset;
  // the word shown is the last one loaded in the previous frame.
  task automatic step(input logic rst, input logic ld, input logic [31:0] d,
                      input logic [7:0] blk, input logic [7:0] dpm, input logic lz);
    exp_t e;
    int k;
    bit wr, sup;
    @(negedge clk_i);
    rst_i = rst; bus.load_i = ld; bus.data_i = d;
    bus.blank_i = blk; bus.dp_i = dpm; bus.lz_en_i = lz;
    if (rst) begin
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fr: 1'b0};
      t = 0; disp_m = '0; frame_loads.delete();
    end else begin
      k   = (t / SD) % 8;
      wr  = (t % FRAME) == FRAME - 1;
      sup = lz && (k > 0) && ((disp_m >> (4 * k)) == 0);
      if (blk[k] || sup) e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fr: wr};
      else e = '{an: ~(8'd1 << k), seg: HEX[(disp_m >> (4 * k)) & 32'hF],
                 dp: ~dpm[k], fr: wr};
      if (ld) frame_loads.push_back(d);
      if (wr) begin
        if (frame_loads.size() > 0) disp_m = frame_loads[$];
        frame_loads.delete();
      end
      t++;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [7:0] blk, input logic [7:0] dpm, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, blk, dpm, lz);
  endtask

  // Monitor: every post-edge sample is an output beat.
  always @(posedge clk_i) begin
    #1;
    if (expq.size() > 0) begin
      exp_t e, a;
      e = expq.pop_front();
      a = '{an: bus.an_o, seg: bus.seg_o, dp: bus.dp_o, fr: bus.frame_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scan t=%0t got an=%h seg=%h dp=%b fr=%b expected an=%h seg=%h dp=%b fr=%b",
                 $time, a.an, a.seg, a.dp, a.fr, e.an, e.seg, e.dp, e.fr);
      end
    end
  end

  initial begin
    bus.load_i = 0; bus.data_i = 0; bus.blank_i = 0; bus.dp_i = 0; bus.lz_en_i = 0;
    t = 0; disp_m = 0;
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
    idle(70, 8'h0, 8'h0, 1'b0);

    // Mid-frame load, then two loads in one frame (last wins).
    idle(5, 8'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 32'h89ABCDEF, 8'h0, 8'h0, 1'b0);
    idle(70, 8'h0, 8'h0, 1'b0);
    while (t % FRAME != 3) idle(1, 8'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 32'h11111111, 8'h0, 8'h0, 1'b0);
    idle(6, 8'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 32'h22222222, 8'h0, 8'h0, 1'b0);
    idle(70, 8'h0, 8'h0, 1'b0);

    // Leading-zero suppression.
    step(1'b0, 1'b1, 32'h00000A05, 8'h0, 8'h0, 1'b1);
    idle(70, 8'h0, 8'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 8'h0, 8'h0, 1'b1);
    idle(70, 8'h0, 8'h0, 1'b1);

    // Blank mask and decimal points.
    step(1'b0, 1'b1, 32'h12345678, 8'h0F, 8'h80, 1'b0);
    idle(70, 8'h0F, 8'h80, 1'b0);

    // Load exactly on wrap, then a mid-frame reset.
    while (t % FRAME != FRAME - 1) idle(1, 8'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 32'hCAFE0123, 8'h0, 8'h0, 1'b0);
    idle(10, 8'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 32'h55555555, 8'h0, 8'h0, 1'b0);
    step(1'b1, 1'b1, 32'h77777777, 8'h0, 8'h0, 1'b0);
    idle(40, 8'h0, 8'h0, 1'b0);

    // Random traffic including occasional reset and loads on wrap.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(199) == 0), ($urandom_range(7) == 0) || ((t % FRAME) == FRAME - 1 && $urandom_range(1) == 1),
           $urandom(), 8'($urandom()) & 8'($urandom()), 8'($urandom()), 1'($urandom()));

    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
